// File: rtl/bin2bcd.sv
// rtl/bin2bcd.sv - 8-bit binary to 3-digit BCD converter, shift-and-add-3, one bit per clock (option: BIN2BCD_STICKY_DONE_EN)
module bin2bcd (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in,
  output logic [3:0] BCD [3],
  output logic       done,
  output logic       ready
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [19:0] work;
  logic [19:0] work_adj;
  logic [19:0] work_shift;
  logic [2:0]  cnt;
  logic        accept;
  logic        last_iter;
  logic        done_state;

  assign accept    = ready & start;
  assign last_iter = (state == SHIFT) && (cnt == 3'd7);

  // One double-dabble step: add 3 to each BCD nibble that is 5 or more, then shift left.
  always_comb begin
    work_adj = work;
    if (work[19:16] >= 4'd5) work_adj[19:16] = work[19:16] + 4'd3;
    if (work[15:12] >= 4'd5) work_adj[15:12] = work[15:12] + 4'd3;
    if (work[11:8]  >= 4'd5) work_adj[11:8]  = work[11:8]  + 4'd3;
    work_shift = work_adj << 1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done_state = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt == 3'd7) state_next = DONE;
      end
      DONE: begin
        done_state = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Working register, iteration counter and result digits; results only move at completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      work   <= 20'd0;
      cnt    <= 3'd0;
      BCD[0] <= 4'd0;
      BCD[1] <= 4'd0;
      BCD[2] <= 4'd0;
    end else if (accept) begin
      work <= {12'd0, in};
      cnt  <= 3'd0;
    end else if (state == SHIFT) begin
      work <= work_shift;
      cnt  <= cnt + 3'd1;
      if (last_iter) begin
        BCD[2] <= work_shift[19:16];
        BCD[1] <= work_shift[15:12];
        BCD[0] <= work_shift[11:8];
      end
    end
  end

`ifdef BIN2BCD_STICKY_DONE_EN
  logic done_hold;

  // Hold done from completion until the next accepted start.
  always_ff @(posedge clk) begin
    if (rst)            done_hold <= 1'b0;
    else if (last_iter) done_hold <= 1'b1;
    else if (accept)    done_hold <= 1'b0;
  end

  assign done = done_hold | done_state;
`else
  assign done = done_state;
`endif

endmodule

// File: tb/tb_bin2bcd.sv
// tb/tb_bin2bcd.sv - directed self-checking bench for bin2bcd
module tb_bin2bcd;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in;
  logic [3:0] BCD [3];
  logic       done;
  logic       ready;
  logic [11:0] bcd_w;

  int vectors    = 0;
  int miscompares = 0;

`ifdef BIN2BCD_STICKY_DONE_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  bin2bcd dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .in    (in),
    .BCD   (BCD),
    .done  (done),
    .ready (ready)
  );

  assign bcd_w = {BCD[2], BCD[1], BCD[0]};

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] dec(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic wait_ready;
    int n = 0;
    while (!ready && n < 20) begin tick; n++; end
    check("ready_timeout", {11'd0, ready}, 12'd1);
  endtask

  task automatic wait_done;
    int n = 0;
    while (!done && n < 20) begin tick; n++; end
    check("done_timeout", {11'd0, done}, 12'd1);
  endtask

  initial begin
    logic saw_done;
    rst = 1'b1; start = 1'b0; in = 8'd0;
    tick; tick;
    rst = 1'b0;

    // Reset state, then quiet idle.
    check("rst_bcd",   bcd_w, 12'h000);
    check("rst_done",  {11'd0, done},  12'd0);
    check("rst_ready", {11'd0, ready}, 12'd1);
    for (int i = 0; i < 10; i++) begin
      tick;
      check("idle_bcd",   bcd_w, 12'h000);
      check("idle_done",  {11'd0, done},  12'd0);
      check("idle_ready", {11'd0, ready}, 12'd1);
    end

    // 255: cycle-by-cycle handshake timing.
    in = 8'hFF; start = 1'b1;
    tick;
    start = 1'b0;
    for (int i = 0; i <= 8; i++) begin
      check("ff_ready_low", {11'd0, ready}, 12'd0);
      if (i < 8) begin
        check("ff_done_low", {11'd0, done}, 12'd0);
        check("ff_bcd_hold", bcd_w, 12'h000);
        tick;
      end else begin
        check("ff_done_high", {11'd0, done}, 12'd1);
        check("ff_bcd", bcd_w, 12'h255);
      end
    end
    tick;
    check("ff_ready_back", {11'd0, ready}, 12'd1);
    check("ff_done_after", {11'd0, done}, {11'd0, STICKY});

    // 147: previous result holds mid-conversion.
    in = 8'b1001_0011; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick; tick;
    check("147_hold", bcd_w, 12'h255);
    wait_done;
    check("147_bcd", bcd_w, 12'h147);

    // Full sweep.
    for (int v = 0; v < 256; v++) begin
      wait_ready;
      in = 8'(v); start = 1'b1;
      tick;
      start = 1'b0;
      wait_done;
      check($sformatf("sweep_%0d", v), bcd_w, dec(v));
    end

    // in changed and start pulsed mid-conversion are ignored.
    wait_ready;
    in = 8'd200; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    in = 8'd55; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done;
    check("midchg_bcd", bcd_w, 12'h200);
    tick;
    check("midchg_ready", {11'd0, ready}, 12'd1);
    tick;
    check("midchg_noqueue", {11'd0, ready}, 12'd1);

    // start held high restarts at every idle edge.
    in = 8'd9; start = 1'b1;
    tick;
    wait_done;
    check("b2b_first", bcd_w, 12'h009);
    in = 8'd10;
    tick;
    check("b2b_idle", {11'd0, ready}, 12'd1);
    tick;
    check("b2b_restart", {11'd0, ready}, 12'd0);
    start = 1'b0;
    wait_done;
    check("b2b_second", bcd_w, 12'h010);

    if (STICKY) begin
      tick;
      for (int i = 0; i < 20; i++) begin
        check("sticky_hold", {11'd0, done}, 12'd1);
        tick;
      end
      in = 8'd99; start = 1'b1;
      tick;
      start = 1'b0;
      check("sticky_drop", {11'd0, done}, 12'd0);
      wait_done;
      check("sticky_bcd", bcd_w, 12'h099);
    end

    // Reset on iteration 4 aborts and clears.
    wait_ready;
    in = 8'd123; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_bcd",   bcd_w, 12'h000);
    check("abort_done",  {11'd0, done},  12'd0);
    check("abort_ready", {11'd0, ready}, 12'd1);
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick;
      if (done) saw_done = 1'b1;
    end
    check("abort_nodone", {11'd0, saw_done}, 12'd0);

    // Reset and start together: reset wins.
    in = 8'd50; rst = 1'b1; start = 1'b1;
    tick;
    rst = 1'b0; start = 1'b0;
    check("rststart_ready", {11'd0, ready}, 12'd1);
    tick;
    check("rststart_idle", {11'd0, ready}, 12'd1);
    check("rststart_bcd", bcd_w, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
